// File: rtl/memoria_pkg.sv
// Shared widths, depth and controller state encoding for the accumulator word store.
package memoria_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/ram_32x16.sv
// Single-port synchronous word store; registered read-before-write output, 1-cycle read latency.
// No backpressure: every enabled access completes on the edge it is sampled.
module ram_32x16
  import memoria_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int ADDR_W_P = ADDR_W
) (
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_W_P-1:0] addr,
  input  logic [DATA_W_P-1:0] wdata,
  output logic [DATA_W_P-1:0] rdata
);

  logic [DATA_W_P-1:0] mem [2**ADDR_W_P];

  // Contents are deliberately unreset; the controller's sweep zeroes them.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/memoria_ctrl.sv
// Word store controller: engine port (1-cycle reads, never stalls), host req/ack port, zeroing sweep.
// Host yields to engine and clear; engine accesses during a sweep are dropped and flagged.
module memoria_ctrl
  import memoria_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ReadEnable,
  input  logic              WriteEnable,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] DataIN,
  output logic [DATA_W-1:0] DataOut,
  input  logic              HostRead,
  input  logic              HostWrite,
  input  logic [ADDR_W-1:0] HostAddr,
  input  logic [DATA_W-1:0] HostWData,
  output logic [DATA_W-1:0] HostRData,
  output logic              HostAck,
  input  logic              ClearReq,
  output logic              Busy,
  output logic              Collision
);

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic                busy_q, coll_q, ack_q, eng_rd_q, host_rd_q;
  logic [DATA_W-1:0]   dout_q, hrd_q;

  logic                ram_we, ram_re;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata, ram_rdata;
  logic                eng_acc, host_acc, host_rd_acc;

  assign eng_acc     = ReadEnable | WriteEnable;
  assign host_acc    = (state == ST_IDLE) && !eng_acc && !ClearReq && (HostRead || HostWrite);
  assign host_rd_acc = host_acc && !HostWrite;

  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (state == ST_CLEAR) begin
      ram_we   = 1'b1;
      ram_addr = cnt;
    end else if (eng_acc) begin
      ram_we    = WriteEnable;
      ram_re    = ReadEnable;
      ram_addr  = Address;
      ram_wdata = DataIN;
    end else if (host_acc) begin
      ram_we    = HostWrite;
      ram_re    = !HostWrite;
      ram_addr  = HostAddr;
      ram_wdata = HostWData;
    end
  end

  ram_32x16 #(.DATA_W_P(DATA_W), .ADDR_W_P(ADDR_W)) u_ram (
    .clk   (Clock),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_CLEAR;
      cnt       <= '0;
      busy_q    <= 1'b1;
      coll_q    <= 1'b0;
      ack_q     <= 1'b0;
      eng_rd_q  <= 1'b0;
      host_rd_q <= 1'b0;
      dout_q    <= '0;
      hrd_q     <= '0;
    end else begin
      // The RAM output is shared; latch it into whichever port read it last cycle.
      if (eng_rd_q)  dout_q <= ram_rdata;
      if (host_rd_q) hrd_q  <= ram_rdata;
      if (state == ST_CLEAR) begin
        eng_rd_q  <= 1'b0;
        ack_q     <= 1'b0;
        host_rd_q <= 1'b0;
        if (eng_acc) coll_q <= 1'b1;
        if (cnt == LAST_ADDR) begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        eng_rd_q  <= ReadEnable;
        ack_q     <= host_acc;
        host_rd_q <= host_rd_acc;
        if (ClearReq) begin
          state  <= ST_CLEAR;
          busy_q <= 1'b1;
          cnt    <= '0;
        end
      end
    end
  end

  assign DataOut   = eng_rd_q  ? ram_rdata : dout_q;
  assign HostRData = host_rd_q ? ram_rdata : hrd_q;
  assign HostAck   = ack_q;
  assign Busy      = busy_q;
  assign Collision = coll_q;

endmodule

// File: doc/memoria_ctrl.md
# memoria_ctrl

Memory-side neighbour of the accumulator datapath: owns the 32×16 word store that the accumulator FSM reads operands from and writes results back to, serving its `ReadEnable`/`WriteEnable`/`Address` port with fixed one-cycle read latency. It also provides:
- a host port to preload operands and read back results, with a request/acknowledge handshake;
- a hardware clear sweep that zeroes the store after reset or on request.

The engine port never stalls. The host yields to the engine, and illegal engine accesses are flagged.

## Interface
Parameters:
- `DATA_W`, 16, word width
- `ADDR_W`, 5, address width; depth = 2**ADDR_W = 32

Ports:
- `Clock`  in  1  rising-edge clock
- `Reset`  in  1  asynchronous, active-low reset
- `ReadEnable`  in  1  engine read request
- `WriteEnable`  in  1  engine write request
- `Address`  in  ADDR_W  engine word address
- `DataIN`  in  DATA_W  engine write data (accumulator result)
- `DataOut`  out  DATA_W  engine read data (accumulator operand)
- `HostRead`  in  1  host read request, held until `HostAck`
- `HostWrite`  in  1  host write request, held until `HostAck`
- `HostAddr`  in  ADDR_W  host word address
- `HostWData`  in  DATA_W  host write data
- `HostRData`  out  DATA_W  host read data, valid with `HostAck`
- `HostAck`  out  1  one-cycle acceptance pulse
- `ClearReq`  in  1  request a zeroing sweep
- `Busy`  out  1  high while clear sweep runs
- `Collision`  out  1  sticky error flag

## Operation
- States: `ST_CLEAR`, `ST_IDLE`.
- Reset asserted (async), all outputs:
  - `DataOut` = 0, `HostRData` = 0, `HostAck` = 0, `Collision` = 0.
  - `Busy` = 1; state = `ST_CLEAR`; sweep counter = 0.
  - The store array itself is not reset; the sweep zeroes it.
- `ST_CLEAR`:
  - Each edge writes 0 to word[counter] and increments the counter.
  - The edge that writes word 31 moves to `ST_IDLE`, deasserts `Busy`, and returns the counter to 0.
  - `ClearReq` is ignored; no restart.
  - Host requests are not acknowledged and remain pending.
  - Any engine `ReadEnable`/`WriteEnable` is dropped: no store change, `DataOut` holds, `Collision` set.
- `ST_IDLE`, priority highest to lowest:
  - `ClearReq`: next edge enters `ST_CLEAR`, `Busy` = 1. Any engine access in that same cycle is still served. Host is not acknowledged.
  - Engine access:
    - `WriteEnable`: word[Address] ← `DataIN`.
    - `ReadEnable`: `DataOut` ← word[Address].
    - Both asserted: read-before-write. `DataOut` gets the old contents; the write happens in the same edge.
    - The host is stalled that cycle; this is not a collision.
  - Host access, only when there is no engine access and no `ClearReq`:
    - `HostWrite` wins over `HostRead`.
    - Write: word[HostAddr] ← `HostWData`.
    - Read: `HostRData` ← word[HostAddr].
    - `HostAck` pulses for one cycle after the accepting edge.
- `DataOut` and `HostRData` hold their last value when not updated.
- `Collision` clears only on reset.

## Timing
- Engine read latency is 1 cycle. `ReadEnable` sampled at edge N gives `DataOut` valid after edge N, for use in cycle N+1.
- An engine write at edge N is visible to a read sampled at edge N+1.
- Host handshake:
  - Request accepted at edge N: `HostAck` = 1 during cycle N+1; `HostRData` is valid in the same cycle.
  - The host must drop or change its request in cycle N+1. A request still held at edge N+1 is treated as a new access.
- Clear sweep:
  - After reset release, the sweep takes exactly 32 edges; `Busy` falls at the 32nd edge.
  - Via `ClearReq`: 1 edge to enter `ST_CLEAR`, then 32 edges.
- Reset asserted mid-sweep or mid-handshake aborts immediately. The sweep restarts at word 0; a pending host request is not acknowledged.
- The address is the full ADDR_W range, so there is no out-of-range case. The counter wraps 31→0 only on the state exit.

## Structure
- Package `memoria_pkg`: `DATA_W`, `ADDR_W`, `DEPTH`, state enum {`ST_CLEAR`, `ST_IDLE`}.
- Sub-module `ram_32x16`:
  - Single-port synchronous store with write enable and registered, read-before-write output.
  - `memoria_ctrl` muxes its address, data and enables among sweep, engine and host.
  - Host read data is captured from the RAM output into `HostRData`.

## Test plan
- Reset release, hold 32 cycles: `Busy` = 1 for 32 edges then 0. Host reads of words 0, 17, 31 return 0x0000 with one `HostAck` each.
- Host writes word 3 = 0x1234 and word 4 = 0x00FF. Engine reads 3 then 4 on consecutive edges: `DataOut` = 0x1234 then 0x00FF, each one cycle after its `ReadEnable`.
- Engine writes word 5 = 0xBEEF while `HostRead` word 5 is pending: host stalls (no `HostAck`). Next cycle the host is acknowledged with `HostRData` = 0xBEEF.
- Engine reads and writes word 6 (old 0x0001, new 0x0002) in the same cycle: `DataOut` = 0x0001. The next read returns 0x0002.
- `ClearReq` in `ST_IDLE`, then engine `ReadEnable` during the sweep: `Collision` = 1 and stays 1, `DataOut` unchanged. After `Busy` falls, all words read 0.
- Reset asserted at sweep word 10: outputs at reset values. After release, a full 32-edge sweep runs again.
